booth_multiplier_param: RTL and testbench

- Parametrised sequential radix-2 Booth multiplier.
- Successor to the fixed 6-bit Booth multiplier. Adds a generic operand width, a per-operation signed/unsigned mode, and a busy/done handshake with a fixed, known latency.
- Used by datapath blocks that need a low-area multiply and can tolerate WIDTH+1 cycles of latency per product.

---
 rtl/booth_multiplier_param.sv | 113 +++++++++++
 tb/tb_booth_multiplier_param.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/booth_multiplier_param.sv
// Sequential radix-2 Booth multiplier: one Booth step per cycle, WIDTH+1 cycles per product.
// While busy, load is ignored and the inputs are not sampled; done pulses once per completed product.
module booth_multiplier_param #(
  parameter int WIDTH = 6,
  parameter int CNT_W = $clog2(WIDTH + 2)
) (
  input  logic                 clk_fast,
  input  logic                 rst,
  input  logic                 load,
  input  logic                 signed_mode,
  input  logic [WIDTH-1:0]     m,
  input  logic [WIDTH-1:0]     r,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product
);

  localparam int E = WIDTH + 1;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t               state_q, state_d;
  logic [E-1:0]         a_q, a_d;
  logic [E-1:0]         q_q, q_d;
  logic                 q1_q, q1_d;
  logic [E-1:0]         m_q, m_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 done_q, done_d;
  logic [2*WIDTH-1:0]   product_q, product_d;

  logic [E-1:0]         sum;
  logic [E-1:0]         a_n;
  logic [E-1:0]         q_n;

  // One Booth step: conditional add/subtract, then arithmetic shift of {A,Q,q_1}.
  always_comb begin
    sum = a_q;
    unique case ({q_q[0], q1_q})
      2'b01:   sum = a_q + m_q;
      2'b10:   sum = a_q - m_q;
      default: sum = a_q;
    endcase
    a_n = {sum[E-1], sum[E-1:1]};
    q_n = {sum[0], q_q[E-1:1]};
  end

  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    q_d       = q_q;
    q1_d      = q1_q;
    m_d       = m_q;
    cnt_d     = cnt_q;
    done_d    = 1'b0;
    product_d = product_q;

    unique case (state_q)
      IDLE: begin
        if (load) begin
          // Extending by one bit lets signed and unsigned share the same iteration.
          m_d     = {signed_mode & m[WIDTH-1], m};
          q_d     = {signed_mode & r[WIDTH-1], r};
          a_d     = '0;
          q1_d    = 1'b0;
          cnt_d   = CNT_W'(E);
          state_d = RUN;
        end
      end
      RUN: begin
        a_d   = a_n;
        q_d   = q_n;
        q1_d  = q_q[0];
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          product_d = {a_n[E-3:0], q_n};
          done_d    = 1'b1;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_fast) begin
    if (!rst) begin
      state_q   <= IDLE;
      a_q       <= '0;
      q_q       <= '0;
      q1_q      <= 1'b0;
      m_q       <= '0;
      cnt_q     <= '0;
      done_q    <= 1'b0;
      product_q <= '0;
    end else begin
      state_q   <= state_d;
      a_q       <= a_d;
      q_q       <= q_d;
      q1_q      <= q1_d;
      m_q       <= m_d;
      cnt_q     <= cnt_d;
      done_q    <= done_d;
      product_q <= product_d;
    end
  end

  assign busy    = (state_q == RUN);
  assign done    = done_q;
  assign product = product_q;

endmodule

// File: tb/tb_booth_multiplier_param.sv
// Self-checking bench for booth_multiplier_param (WIDTH=6): directed corners plus random operands
// compared against a plain integer multiply.
module tb_booth_multiplier_param;

  localparam int W = 6;

  logic             clk_fast = 1'b0;
  logic             rst = 1'b0;
  logic             load = 1'b0;
  logic             signed_mode = 1'b0;
  logic [W-1:0]     m = '0;
  logic [W-1:0]     r = '0;
  logic             busy;
  logic             done;
  logic [2*W-1:0]   product;

  int n_checks = 0;
  int n_fail   = 0;

  booth_multiplier_param #(.WIDTH(W)) dut (
    .clk_fast    (clk_fast),
    .rst         (rst),
    .load        (load),
    .signed_mode (signed_mode),
    .m           (m),
    .r           (r),
    .busy        (busy),
    .done        (done),
    .product     (product)
  );

  always #5 clk_fast = ~clk_fast;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [2*W-1:0] ref_mul(input logic [W-1:0] mv, input logic [W-1:0] rv,
                                             input logic sm);
    longint a;
    longint b;
    longint p;
    a = sm ? longint'($signed(mv)) : longint'(mv);
    b = sm ? longint'($signed(rv)) : longint'(rv);
    p = a * b;
    return p[2*W-1:0];
  endfunction

  task automatic tick();
    @(posedge clk_fast);
    #1;
  endtask

  // Apply load in the current cycle; returns just after the load edge.
  task automatic start(input logic [W-1:0] mv, input logic [W-1:0] rv, input logic sm);
    load        = 1'b1;
    m           = mv;
    r           = rv;
    signed_mode = sm;
    tick();
    load        = 1'b0;
    m           = W'($urandom);
    r           = W'($urandom);
    signed_mode = 1'($urandom);
  endtask

  // Wait for done, counting edges and busy cycles since the load edge.
  task automatic wait_done(input string tag, input logic [2*W-1:0] exp);
    int n;
    int busy_cyc;
    n        = 0;
    busy_cyc = busy ? 1 : 0;
    while (!done && n < 40) begin
      tick();
      n++;
      if (busy) busy_cyc++;
    end
    check({tag, " latency"}, 64'(n), 64'(W + 1));
    check({tag, " busy cycles"}, 64'(busy_cyc), 64'(W + 1));
    check({tag, " product"}, 64'(product), 64'(exp));
  endtask

  task automatic do_op(input string tag, input logic [W-1:0] mv, input logic [W-1:0] rv,
                       input logic sm, input logic [2*W-1:0] exp);
    @(negedge clk_fast);
    start(mv, rv, sm);
    wait_done(tag, exp);
    tick();
    check({tag, " done one cycle"}, 64'(done), 64'(0));
  endtask

  initial begin
    logic [W-1:0] rm;
    logic [W-1:0] rr;
    logic         rs;
    int           extra_done;

    repeat (3) tick();
    check("reset busy", 64'(busy), 64'(0));
    check("reset done", 64'(done), 64'(0));
    check("reset product", 64'(product), 64'(0));
    rst = 1'b1;
    tick();

    do_op("u 7x3", 6'd7, 6'd3, 1'b0, 12'h015);
    do_op("s -7x3", 6'b111001, 6'd3, 1'b1, 12'hFEB);
    do_op("u 57x3", 6'b111001, 6'd3, 1'b0, 12'h0AB);
    do_op("s -32x-32", 6'b100000, 6'b100000, 1'b1, 12'h400);
    do_op("u 63x63", 6'd63, 6'd63, 1'b0, 12'hF81);
    do_op("s 31x-32", 6'b011111, 6'b100000, 1'b1, 12'hC20);

    // Load pulse mid-run must be ignored.
    start(6'd11, 6'd13, 1'b0);
    tick();
    load = 1'b1; m = 6'd5; r = 6'd5;
    tick();
    load = 1'b0;
    extra_done = 0;
    begin
      int n;
      n = 2;
      while (!done && n < 40) begin tick(); n++; end
      check("midload latency", 64'(n), 64'(W + 1));
    end
    check("midload product", 64'(product), 64'(ref_mul(6'd11, 6'd13, 1'b0)));
    for (int i = 0; i < W + 3; i++) begin
      tick();
      if (done) extra_done++;
    end
    check("midload no extra done", 64'(extra_done), 64'(0));

    // Back-to-back: load asserted in the done cycle.
    start(6'd9, 6'd6, 1'b1);
    begin
      int n;
      n = 0;
      while (!done && n < 40) begin tick(); n++; end
      check("b2b first product", 64'(product), 64'(ref_mul(6'd9, 6'd6, 1'b1)));
    end
    start(6'd2, 6'd9, 1'b0);
    check("b2b done cleared", 64'(done), 64'(0));
    check("b2b busy", 64'(busy), 64'(1));
    wait_done("b2b second", 12'h012);

    // Reset on the 3rd RUN cycle aborts the run.
    tick();
    start(6'd21, 6'd17, 1'b0);
    tick();
    tick();
    rst = 1'b0;
    tick();
    rst = 1'b1;
    check("abort busy", 64'(busy), 64'(0));
    check("abort done", 64'(done), 64'(0));
    check("abort product", 64'(product), 64'(0));
    begin
      int n;
      n = 0;
      while (!done && n < 12) begin tick(); n++; end
      check("abort no done", 64'(done), 64'(0));
    end
    do_op("after abort 4x4", 6'd4, 6'd4, 1'b0, 12'h010);

    for (int i = 0; i < 40; i++) begin
      rm = W'($urandom);
      rr = W'($urandom);
      rs = 1'($urandom);
      do_op($sformatf("rand%0d %s %0d*%0d", i, rs ? "s" : "u", rm, rr), rm, rr, rs,
            ref_mul(rm, rr, rs));
    end

    $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
    $finish;
  end

endmodule
